// File: rtl/wb_rfile.sv
// Writeback stage: T2->T3 pipeline register, load-data extraction, and a
// 2^ADDR_RFILE-entry register file with two asynchronous read ports.
module wb_rfile #(
    parameter int WIDTH_D    = 32,
    parameter int ADDR_RFILE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_rfile_w,
    input  logic [ADDR_RFILE-1:0] in_wb_addr,
    input  logic                  in_mem_to_reg,
    input  logic [WIDTH_D-1:0]    in_alu_result,
    input  logic [WIDTH_D-1:0]    in_mem_data,
    input  logic [2:0]            in_ld_type,
    input  logic [1:0]            in_byte_off,
    input  logic [ADDR_RFILE-1:0] ra_addr,
    input  logic [ADDR_RFILE-1:0] rb_addr,
    output logic [WIDTH_D-1:0]    ra_data,
    output logic [WIDTH_D-1:0]    rb_data,
    output logic                  rfile_w_t3,
    output logic [ADDR_RFILE-1:0] wb_addr,
    output logic [WIDTH_D-1:0]    wb_data,
    output logic [31:0]           retire_cnt
);

    localparam int unsigned N_REG = 2 ** ADDR_RFILE;

    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [WIDTH_D-1:0] load_data;
    logic [WIDTH_D-1:0] t2_data;
    logic               wb_valid;
    logic               wb_rfile_w;
    logic [WIDTH_D-1:0] rf [N_REG];

    // Little-endian lane select; halfword lane ignores byte_off[0].
    always_comb begin
        ld_byte = in_mem_data[{in_byte_off, 3'b000} +: 8];
        ld_half = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
        case (in_ld_type)
            3'd1:    load_data = {{(WIDTH_D-16){ld_half[15]}}, ld_half};
            3'd2:    load_data = {{(WIDTH_D-16){1'b0}}, ld_half};
            3'd3:    load_data = {{(WIDTH_D-8){ld_byte[7]}}, ld_byte};
            3'd4:    load_data = {{(WIDTH_D-8){1'b0}}, ld_byte};
            default: load_data = in_mem_data;
        endcase
        t2_data = in_mem_to_reg ? load_data : in_alu_result;
    end

    // Flush wins over stall so a stalled, flushed stage still drops its instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_rfile_w <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            wb_rfile_w <= 1'b0;
        end else if (!stall) begin
            wb_valid   <= in_valid;
            wb_rfile_w <= in_rfile_w;
            wb_addr    <= in_wb_addr;
            wb_data    <= t2_data;
        end
    end

    assign rfile_w_t3 = wb_valid & wb_rfile_w & (wb_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REG; i++) begin
                rf[i] <= '0;
            end
        end else if (rfile_w_t3 && !stall) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : rf[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : rf[rb_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (wb_valid && !stall) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_rfile.sv
module tb_wb_rfile;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, in_rfile_w, in_mem_to_reg;
  logic [4:0]  in_wb_addr, ra_addr, rb_addr, wb_addr;
  logic [31:0] in_alu_result, in_mem_data, ra_data, rb_data, wb_data, retire_cnt;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_byte_off;
  logic        rfile_w_t3;

  wb_rfile #(.WIDTH_D(32), .ADDR_RFILE(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rfile_w(in_rfile_w), .in_wb_addr(in_wb_addr),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_ld_type(in_ld_type), .in_byte_off(in_byte_off),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .rfile_w_t3(rfile_w_t3), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {S_T3, S_ADDR, S_DATA, S_RA, S_RB, S_CNT} sel_e;

  typedef struct {
    int unsigned cyc;
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned dly, input sel_e sel, input logic [31:0] exp,
                           input string name);
    exp_t e;
    e.cyc = cyc + dly; e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_T3:    return {31'd0, rfile_w_t3};
      S_ADDR:  return {27'd0, wb_addr};
      S_DATA:  return wb_data;
      S_RA:    return ra_data;
      S_RB:    return rb_data;
      default: return retire_cnt;
    endcase
  endfunction

  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        act = observe(sb[i].sel);
        if (sb[i].cyc == cyc && act === sb[i].exp) n_pass++;
        else $display("FAIL %s cyc %0d: got 0x%08h expected 0x%08h",
                      sb[i].name, cyc, act, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic w, input logic [4:0] a, input logic m2r,
                       input logic [31:0] alu, input logic [2:0] ld, input logic [1:0] off);
    in_valid = v; in_rfile_w = w; in_wb_addr = a; in_mem_to_reg = m2r;
    in_alu_result = alu; in_ld_type = ld; in_byte_off = off;
  endtask

  task automatic bubble();
    issue(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
  endtask

  logic [2:0]  ld_t [6] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd6, 3'd1};
  logic [1:0]  ld_o [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3};
  logic [31:0] ld_e [6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                            32'h00007F01, 32'h80FF7F01, 32'hFFFF80FF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    ra_addr = '0; rb_addr = '0; in_mem_data = 32'h80FF7F01;
    bubble();
    tick(); tick();
    expect_at(0, S_T3, 0, "reset_t3");
    expect_at(0, S_ADDR, 0, "reset_addr");
    expect_at(0, S_DATA, 0, "reset_data");
    expect_at(0, S_CNT, 0, "reset_cnt");
    tick();
    rst_n = 1'b1;
    tick();

    issue(1'b1, 1'b1, 5'd5, 1'b0, 32'h12345678, 3'd0, 2'd0);
    expect_at(1, S_T3, 1, "alu_t3");
    expect_at(1, S_ADDR, 5, "alu_addr");
    expect_at(1, S_DATA, 32'h12345678, "alu_data");
    tick();
    n_checks++;
    if (rfile_w_t3 === 1'b1 && wb_addr === 5'd5) n_pass++;
    else $display("FAIL direct alu_cap: t3=%b addr=%0d", rfile_w_t3, wb_addr);
    bubble(); ra_addr = 5'd5;
    expect_at(0, S_RA, 0, "no_bypass");
    expect_at(1, S_RA, 32'h12345678, "alu_rf");
    expect_at(1, S_CNT, 1, "alu_cnt");
    tick();
    n_checks++;
    if (ra_data === 32'h12345678 && retire_cnt === 32'd1) n_pass++;
    else $display("FAIL direct alu_rf: ra=0x%08h cnt=%0d", ra_data, retire_cnt);
    tick();

    for (int unsigned k = 0; k < 6; k++) begin
      issue(1'b1, 1'b1, 5'(k + 1), 1'b1, 32'hCAFE0000, ld_t[k], ld_o[k]);
      expect_at(1, S_DATA, ld_e[k], $sformatf("load%0d", k));
      tick();
      n_checks++;
      if (wb_data === ld_e[k]) n_pass++;
      else $display("FAIL direct load%0d: got 0x%08h expected 0x%08h", k, wb_data, ld_e[k]);
    end
    bubble(); ra_addr = 5'd5; rb_addr = 5'd2;
    expect_at(1, S_RA, 32'h80FF7F01, "load_r5");
    expect_at(1, S_RB, 32'h0000007F, "load_r2");
    expect_at(1, S_CNT, 7, "load_cnt");
    tick(); tick();

    issue(1'b1, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 3'd0, 2'd0);
    expect_at(1, S_T3, 0, "r0_t3");
    expect_at(1, S_DATA, 32'hDEADBEEF, "r0_data");
    tick();
    n_checks++;
    if (rfile_w_t3 === 1'b0) n_pass++;
    else $display("FAIL direct r0_t3: t3=%b", rfile_w_t3);
    bubble(); ra_addr = 5'd0;
    expect_at(1, S_RA, 0, "r0_read");
    expect_at(1, S_CNT, 8, "r0_cnt");
    tick(); tick();

    issue(1'b1, 1'b1, 5'd7, 1'b0, 32'hAA, 3'd0, 2'd0);
    expect_at(1, S_T3, 1, "stall_cap");
    tick();
    bubble(); ra_addr = 5'd7; stall = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      expect_at(0, S_T3, 1, $sformatf("stall_t3_%0d", k));
      expect_at(0, S_RA, 0, $sformatf("stall_r7_%0d", k));
      expect_at(0, S_CNT, 8, $sformatf("stall_cnt_%0d", k));
      if (k < 2) tick();
    end
    n_checks++;
    if (rfile_w_t3 === 1'b1 && ra_data === 32'h0) n_pass++;
    else $display("FAIL direct stall: t3=%b r7=0x%08h", rfile_w_t3, ra_data);
    tick();
    stall = 1'b0;
    issue(1'b1, 1'b1, 5'd8, 1'b0, 32'h55, 3'd0, 2'd0);
    expect_at(1, S_RA, 32'hAA, "unstall_r7");
    expect_at(1, S_CNT, 9, "unstall_cnt");
    expect_at(1, S_ADDR, 8, "r8_pending");
    tick();

    flush = 1'b1; stall = 1'b1;
    issue(1'b1, 1'b1, 5'd10, 1'b0, 32'h66, 3'd0, 2'd0);
    expect_at(1, S_T3, 0, "flush_t3");
    expect_at(1, S_CNT, 9, "flush_cnt");
    tick();
    n_checks++;
    if (rfile_w_t3 === 1'b0) n_pass++;
    else $display("FAIL direct flush_t3: t3=%b", rfile_w_t3);
    flush = 1'b0; stall = 1'b0;
    bubble(); ra_addr = 5'd8; rb_addr = 5'd10;
    expect_at(1, S_RA, 0, "flush_r8");
    expect_at(1, S_RB, 0, "flush_r10");
    expect_at(1, S_CNT, 9, "flush_cnt2");
    tick(); tick();

    issue(1'b1, 1'b1, 5'd9, 1'b0, 32'h99, 3'd0, 2'd0);
    tick();
    bubble(); ra_addr = 5'd9; rb_addr = 5'd7;
    #2;
    rst_n = 1'b0;
    expect_at(0, S_T3, 0, "rst_t3");
    expect_at(0, S_CNT, 0, "rst_cnt");
    expect_at(0, S_ADDR, 0, "rst_addr");
    expect_at(0, S_RA, 0, "rst_r9");
    expect_at(0, S_RB, 0, "rst_r7");
    #1;
    n_checks++;
    if (retire_cnt === 32'd0 && rfile_w_t3 === 1'b0 && ra_data === 32'd0) n_pass++;
    else $display("FAIL direct rst: cnt=%0d t3=%b r9=0x%08h", retire_cnt, rfile_w_t3, ra_data);
    tick();
    rst_n = 1'b1;
    expect_at(1, S_RA, 0, "post_rst_r9");
    tick(); tick();

    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    expect_at(0, S_CNT, 32'hFFFFFFFF, "wrap_pre");
    issue(1'b1, 1'b1, 5'd11, 1'b0, 32'h77, 3'd0, 2'd0);
    expect_at(1, S_CNT, 32'hFFFFFFFF, "wrap_hold");
    tick();
    bubble(); rb_addr = 5'd11;
    expect_at(1, S_CNT, 0, "wrap_cnt");
    expect_at(1, S_RB, 32'h77, "wrap_r11");
    tick();
    n_checks++;
    if (retire_cnt === 32'd0) n_pass++;
    else $display("FAIL direct wrap: cnt=0x%08h", retire_cnt);
    tick(); tick();

    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: expectation never checked, expected 0x%08h",
               sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
